// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write side.
package regfile_pkg;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

   function automatic logic is_last_reg(input logic [ADDR_W-1:0] idx);
      return idx == ADDR_W'(NUM_REGS - 1);
   endfunction

endpackage

// File: rtl/decoder5_32.sv
// Address to one-hot register-enable decoder; all outputs low when en is low.
module decoder5_32
   import regfile_pkg::*;
(
   input  logic                en,
   input  logic [ADDR_W-1:0]   addr,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_write_port.sv
// Write port and storage of the 32x64 register file with a sequenced bulk-clear engine.
// Optional macro ZERO_REG_EN hardwires the last register (X31) to zero.
module regfile_write_port
   import regfile_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                clr_req,
   output logic                busy,
   output logic [NUM_REGS-1:0] wr_en_oh,
   output reg_array_t          regs
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
   reg_array_t            regs_q, regs_d;
   logic [NUM_REGS-1:0]   wr_en_oh_q, wr_en_oh_d;
   logic [NUM_REGS-1:0]   wr_sel;
   logic                  accept;
   logic                  dec_en;

   assign wr_ready = (state_q == IDLE);
   assign accept   = wr_valid & wr_ready;

`ifdef ZERO_REG_EN
   // Writes to X31 still complete the handshake but never reach storage or wr_en_oh.
   assign dec_en = accept & ~is_last_reg(wr_addr);
`else
   assign dec_en = accept;
`endif

   decoder5_32 u_decoder (
      .en     (dec_en),
      .addr   (wr_addr),
      .onehot (wr_sel)
   );

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (is_last_reg(clr_cnt_q)) begin
               state_d   = IDLE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         regs_d[i] = regs_q[i];
         if (wr_sel[i]) begin
            regs_d[i] = wr_data;
         end
         if ((state_q == CLEAR) && (clr_cnt_q == ADDR_W'(i))) begin
            regs_d[i] = '0;
         end
      end
`ifdef ZERO_REG_EN
      regs_d[NUM_REGS-1] = '0;
`endif
   end

   // Decoder is gated by accept, so this is already zero throughout CLEAR.
   assign wr_en_oh_d = wr_sel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         clr_cnt_q  <= '0;
         regs_q     <= '0;
         wr_en_oh_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_cnt_q  <= clr_cnt_d;
         regs_q     <= regs_d;
         wr_en_oh_q <= wr_en_oh_d;
      end
   end

   assign busy     = (state_q == CLEAR);
   assign wr_en_oh = wr_en_oh_q;
   assign regs     = regs_q;

endmodule
